// File: rtl/snn_axil_cmd_master_if.sv
// Command/response port plus AXI4-Lite master bus for snn_axil_cmd_master.
// The master modport is the initiator side; slave is the controller/slave peer side.
interface snn_axil_cmd_master_if #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_write;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_W-1:0]             cmd_wstrb;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic                          rsp_write;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]                    rsp_resp;

    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic                          M_AXI_AWVALID;
    logic                          M_AXI_AWREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [STRB_W-1:0]             M_AXI_WSTRB;
    logic                          M_AXI_WVALID;
    logic                          M_AXI_WREADY;
    logic [1:0]                    M_AXI_BRESP;
    logic                          M_AXI_BVALID;
    logic                          M_AXI_BREADY;
    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );
endinterface

// File: rtl/snn_axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns valid/ready read/write commands
// into AXI4-Lite transactions and returns each result on a held response port.
module snn_axil_cmd_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    snn_axil_cmd_master_if.master bus,
    input  logic                  timeout_clr,
    output logic                  timeout_err,
    output logic                  busy
);
    localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                        r_state, w_state_nxt;
    logic                          r_cmd_ready, r_busy;
    logic                          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                          w_awvalid_nxt, w_wvalid_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata, r_rsp_rdata;
    logic [STRB_W-1:0]             r_wstrb;
    logic                          r_rsp_valid, r_rsp_write;
    logic [1:0]                    r_rsp_resp;
    logic                          r_timeout_err;
    logic [CNT_W-1:0]              r_wdog;
    logic                          w_accept, w_wait, w_to_set;

    assign w_accept = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;
    assign w_wait   = (r_state == S_WR_AW_W) || (r_state == S_WR_B) ||
                      (r_state == S_RD_AR)   || (r_state == S_RD_R);
    assign w_to_set = (TIMEOUT_CYCLES != 0) && w_wait &&
                      (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    // Next state plus the AW/W valids, which drop independently on their own handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.cmd_write) begin
                        w_state_nxt   = S_WR_AW_W;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_RD_AR;
                    end
                end
            end
            S_WR_AW_W: begin
                w_awvalid_nxt = r_awvalid && !bus.M_AXI_AWREADY;
                w_wvalid_nxt  = r_wvalid && !bus.M_AXI_WREADY;
                if (!w_awvalid_nxt && !w_wvalid_nxt) w_state_nxt = S_WR_B;
            end
            S_WR_B:  if (bus.M_AXI_BVALID)  w_state_nxt = S_RSP;
            S_RD_AR: if (bus.M_AXI_ARREADY) w_state_nxt = S_RD_R;
            S_RD_R:  if (bus.M_AXI_RVALID)  w_state_nxt = S_RSP;
            S_RSP:   if (bus.rsp_ready)     w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered straight from the next state.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= (w_state_nxt == S_WR_B);
            r_arvalid   <= (w_state_nxt == S_RD_AR);
            r_rready    <= (w_state_nxt == S_RD_R);
            r_rsp_valid <= (w_state_nxt == S_RSP);
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            if (w_accept && bus.cmd_write) begin
                r_awaddr <= bus.cmd_addr;
                r_wdata  <= bus.cmd_wdata;
                r_wstrb  <= bus.cmd_wstrb;
            end
            if (w_accept && !bus.cmd_write) r_araddr <= bus.cmd_addr;
            if ((r_state == S_WR_B) && bus.M_AXI_BVALID) begin
                r_rsp_write <= 1'b1;
                r_rsp_rdata <= '0;
                r_rsp_resp  <= bus.M_AXI_BRESP;
            end
            if ((r_state == S_RD_R) && bus.M_AXI_RVALID) begin
                r_rsp_write <= 1'b0;
                r_rsp_rdata <= bus.M_AXI_RDATA;
                r_rsp_resp  <= bus.M_AXI_RRESP;
            end
        end
    end

    // Watchdog only flags a stuck slave; the transaction keeps waiting.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept)
                r_wdog <= '0;
            else if (w_wait && (r_wdog != CNT_W'(TIMEOUT_CYCLES)))
                r_wdog <= r_wdog + 1'b1;
            if (w_to_set)         r_timeout_err <= 1'b1;
            else if (timeout_clr) r_timeout_err <= 1'b0;
        end
    end

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_write     = r_rsp_write;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_resp      = r_rsp_resp;
    assign bus.M_AXI_AWADDR  = r_awaddr;
    assign bus.M_AXI_AWVALID = r_awvalid;
    assign bus.M_AXI_WDATA   = r_wdata;
    assign bus.M_AXI_WSTRB   = r_wstrb;
    assign bus.M_AXI_WVALID  = r_wvalid;
    assign bus.M_AXI_BREADY  = r_bready;
    assign bus.M_AXI_ARADDR  = r_araddr;
    assign bus.M_AXI_ARVALID = r_arvalid;
    assign bus.M_AXI_RREADY  = r_rready;
    assign timeout_err       = r_timeout_err;
    assign busy              = r_busy;
endmodule

// File: doc/snn_axil_cmd_master.md
Name: snn_axil_cmd_master

Overview:
- Hardware AXI4-Lite initiator that drives the snn_core_top register/memory slave port from on-chip logic, with no PS/testbench master involved.
- Accepts single-beat read/write commands on a simple valid/ready command port and runs them as AXI4-Lite transactions.
- Returns each response on a held response port.
- Sits between an on-chip controller (weight/spike loader, result reader) and the snn_core_top S_AXI port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 16, address width of command and AXI address channels
- C_M_AXI_DATA_WIDTH, 32, data width; strobe width = C_M_AXI_DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, watchdog limit per transaction; 0 disables the watchdog

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP captured from the slave
- timeout_err  out  1  sticky watchdog flag
- timeout_clr  in  1  clears timeout_err
- busy  out  1  high in any state other than IDLE
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths

Behaviour:
- Reset (async assert, sync release): state=IDLE; all VALID/READY outputs 0; AWADDR/ARADDR/WDATA/WSTRB 0; rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_write 0; timeout_err 0; busy 0. Reset mid-transaction drops all VALIDs immediately; no response is produced.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- cmd_ready = (state==IDLE). On accept, address/data/strobe/type are registered.
  - Write: next state WR_AW_W.
  - Read: next state RD_AR.
- WR_AW_W:
  - AWVALID and WVALID both assert on the first cycle in the state.
  - Each VALID deasserts the cycle after its own READY is sampled high. AWREADY and WREADY may arrive in either order or together.
  - Move to WR_B once both handshakes are complete.
  - Address/data stay stable while VALID is high.
- WR_B: BREADY=1. On BVALID, capture BRESP and go to RSP (rsp_write=1, rsp_rdata=0).
- RD_AR: ARVALID=1 until ARREADY is sampled, then go to RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA/RRESP and go to RSP (rsp_write=0).
- RSP: rsp_valid=1 and all rsp_* stable until rsp_ready, then return to IDLE. rsp_valid && rsp_ready cannot overlap with command accept in the same cycle.
- Zero-wait slave latency:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: same cycle timing via AR/R.
- Exactly one outstanding transaction. BREADY and RREADY are never high outside WR_B and RD_R.
- Watchdog:
  - Counter clears on command accept and increments every cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set (sticky). The transaction is NOT aborted; the FSM keeps waiting.
  - timeout_clr clears the flag. If a set event and timeout_clr occur in the same cycle, set wins.
- The counter saturates; it does not wrap.

Test Plan:
- Zero-wait slave, write 0x0008 <= 0x00000001, wstrb 0xF -> AWADDR=0x0008 and WDATA=0x1 handshake at cycle 1, rsp_valid at cycle 3 with rsp_write=1, rsp_resp=00.
- Slave holds AWREADY low 3 cycles and WREADY high immediately -> WVALID drops after 1 cycle, AWVALID held 4 cycles, single B handshake, one response.
- Read 0x0100 with slave returning RDATA=0xDEADBEEE after 5 wait cycles -> rsp_rdata=0xDEADBEEE, rsp_write=0, no extra ARVALID pulses.
- rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0 throughout, next command accepted the cycle after rsp_ready.
- TIMEOUT_CYCLES=8, slave never asserts BVALID for 20 cycles -> timeout_err=1 after 8 cycles in WR_AW_W/WR_B, then normal completion; timeout_clr pulse -> flag 0.
- Assert M_AXI_ARESET while RD_R is waiting -> RREADY, ARVALID and busy go to 0 asynchronously; after release, a new write completes normally.
